// File: rtl/tlb_maint_ctrl_pkg.sv
// tlb_maint_ctrl_pkg: TLB geometry, tag layout, maintenance FSM states and the flush VPN compare
package tlb_maint_ctrl_pkg;
    localparam int TLB_ENTRIES = 16;
    localparam int ASID_WIDTH = 16;
    localparam int VA_SIZE = 39;
    localparam int VPN_W = 27;
    localparam int IDX_W = $clog2(TLB_ENTRIES);
    typedef struct packed {
        logic [ASID_WIDTH-1:0] asid;
        logic [8:0] vpn2;
        logic [8:0] vpn1;
        logic [8:0] vpn0;
        logic is_2M;
        logic is_1G;
        logic valid;
    } tag_t;
    typedef enum logic [1:0] {IDLE, WALK, DONE} state_e;
    // Superpages ignore the VPN levels their page offset swallows
    function automatic logic vpn_match(tag_t t, logic [VPN_W-1:0] vpn);
        return t.vpn2 == vpn[26:18] && (t.is_1G || t.vpn1 == vpn[17:9]) &&
               (t.is_1G || t.is_2M || t.vpn0 == vpn[8:0]);
    endfunction
endpackage

// File: rtl/tlb_maint_ctrl_if.sv
// tlb_maint_ctrl_if: fill/flush handshakes, CAM hit vector and exported tag array
interface tlb_maint_ctrl_if;
    import tlb_maint_ctrl_pkg::*;
    logic fill_valid_i;
    logic fill_ready_o;
    logic [ASID_WIDTH-1:0] fill_asid_i;
    logic [VPN_W-1:0] fill_vpn_i;
    logic fill_is_2M_i;
    logic fill_is_1G_i;
    logic flush_valid_i;
    logic flush_ready_o;
    logic flush_asid_en_i;
    logic flush_vaddr_en_i;
    logic [ASID_WIDTH-1:0] flush_asid_i;
    logic [VA_SIZE-1:0] flush_vaddr_i;
    logic flush_done_o;
    logic [TLB_ENTRIES-1:0] lookup_hit_i;
    tag_t [TLB_ENTRIES-1:0] tags_o;
    logic [IDX_W-1:0] victim_o;
    logic busy_o;
    modport master (
        output fill_valid_i, fill_asid_i, fill_vpn_i, fill_is_2M_i, fill_is_1G_i,
        output flush_valid_i, flush_asid_en_i, flush_vaddr_en_i, flush_asid_i, flush_vaddr_i,
        output lookup_hit_i,
        input fill_ready_o, flush_ready_o, flush_done_o, tags_o, victim_o, busy_o
    );
    modport slave (
        input fill_valid_i, fill_asid_i, fill_vpn_i, fill_is_2M_i, fill_is_1G_i,
        input flush_valid_i, flush_asid_en_i, flush_vaddr_en_i, flush_asid_i, flush_vaddr_i,
        input lookup_hit_i,
        output fill_ready_o, flush_ready_o, flush_done_o, tags_o, victim_o, busy_o
    );
endinterface

// File: rtl/tlb_maint_ctrl_plru.sv
// tlb_plru_tree: tree pseudo-LRU; hits then fills point each node on the path away from the touched entry
module tlb_plru_tree #(
    parameter int N = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic [N-1:0] hit,
    input  logic fill_en,
    input  logic [$clog2(N)-1:0] fill_idx,
    output logic [$clog2(N)-1:0] victim
);
    localparam int L = $clog2(N);
    logic [N-2:0] tree, tree_nxt;
    logic [L-1:0] hit_idx;
    always_comb begin
        hit_idx = '0;
        for (int i = N - 1; i >= 0; i--) hit_idx = hit[i] ? L'(i) : hit_idx;
    end
    // Heap layout: node n has children 2n+1 (lower half) and 2n+2 (upper half)
    always_comb begin
        tree_nxt = tree;
        for (int d = 0; d < L; d++) begin
            if (|hit) tree_nxt[(1 << d) - 1 + (int'(hit_idx) >> (L - d))] = !hit_idx[L-1-d];
            if (fill_en) tree_nxt[(1 << d) - 1 + (int'(fill_idx) >> (L - d))] = !fill_idx[L-1-d];
        end
    end
    always_comb begin : descend
        int n;
        n = 0;
        victim = '0;
        for (int d = 0; d < L; d++) begin
            victim = L'({victim, tree[n]});
            n = 2 * n + 1 + int'(tree[n]);
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) tree <= '0;
        else tree <= tree_nxt;
    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(hit));
endmodule

// File: rtl/tlb_maint_ctrl.sv
// tlb_maint_ctrl: owns TLB tags; sequences fills, PLRU replacement and sfence.vma walks
module tlb_maint_ctrl
    import tlb_maint_ctrl_pkg::*;
(
    input logic clk_i,
    input logic rst_ni,
    tlb_maint_ctrl_if.slave bus
);
    tag_t [TLB_ENTRIES-1:0] tags;
    state_e state;
    logic [IDX_W-1:0] cnt, victim, plru_victim;
    logic f_asid_en, f_vaddr_en;
    logic [ASID_WIDTH-1:0] f_asid;
    logic [VPN_W-1:0] f_vpn;
    logic fill_acc, flush_acc, kill, unused_ok;
    assign bus.flush_ready_o = rst_ni && state == IDLE;
    assign bus.fill_ready_o = bus.flush_ready_o && !bus.flush_valid_i;
    assign fill_acc = bus.fill_valid_i && bus.fill_ready_o;
    assign flush_acc = bus.flush_valid_i && bus.flush_ready_o;
    assign bus.flush_done_o = state == DONE;
    assign bus.busy_o = state != IDLE;
    assign bus.tags_o = tags;
    assign bus.victim_o = victim;
    assign unused_ok = ^bus.flush_vaddr_i[11:0];
    assign kill = tags[cnt].valid && (!f_asid_en || tags[cnt].asid == f_asid) &&
                  (!f_vaddr_en || vpn_match(tags[cnt], f_vpn));
    always_comb begin
        victim = plru_victim;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) victim = tags[i].valid ? victim : IDX_W'(i);
    end
    tlb_plru_tree #(.N(TLB_ENTRIES)) u_plru (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .hit(bus.lookup_hit_i),
        .fill_en(fill_acc),
        .fill_idx(victim),
        .victim(plru_victim)
    );
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state <= IDLE;
            cnt <= '0;
            tags <= '0;
            f_asid_en <= 1'b0;
            f_vaddr_en <= 1'b0;
            f_asid <= '0;
            f_vpn <= '0;
        end else begin
            if (fill_acc) tags[victim] <= '{asid: bus.fill_asid_i, vpn2: bus.fill_vpn_i[26:18],
                                           vpn1: bus.fill_vpn_i[17:9], vpn0: bus.fill_vpn_i[8:0],
                                           is_2M: bus.fill_is_2M_i && !bus.fill_is_1G_i,
                                           is_1G: bus.fill_is_1G_i, valid: 1'b1};
            case (state)
                IDLE: if (flush_acc) begin
                    state <= WALK;
                    cnt <= '0;
                    f_asid_en <= bus.flush_asid_en_i;
                    f_vaddr_en <= bus.flush_vaddr_en_i;
                    f_asid <= bus.flush_asid_i;
                    f_vpn <= bus.flush_vaddr_i[VA_SIZE-1:12];
                end
                WALK: begin
                    if (kill) tags[cnt].valid <= 1'b0;
                    cnt <= cnt + IDX_W'(1);
                    state <= cnt == IDX_W'(TLB_ENTRIES - 1) ? DONE : WALK;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// tb_tlb_maint_ctrl: scoreboard bench against a range-halving PLRU and mask-based flush model
module tb_tlb_maint_ctrl;
    import tlb_maint_ctrl_pkg::*;
    typedef struct {
        bit is_flush;
        int idx;
        tag_t tag;
        int vic;
        logic [15:0] valids;
        int t_acc;
    } exp_t;
    logic clk = 0;
    logic rst_n = 0;
    tlb_maint_ctrl_if bus();
    tlb_maint_ctrl dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
    always #5 clk = ~clk;
    int cyc = 0, n_cmp = 0, n_bad = 0, walk_end = 0, t_flush = 0, acc_cyc = 0;
    bit rnd_hits = 0, fill_acc = 0, flush_acc = 0;
    tag_t m_tag [16];
    bit m_pl [4][8];
    exp_t q[$];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [15:0] dut_valids();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = bus.tags_o[i].valid;
        return v;
    endfunction

    function automatic logic [15:0] m_valids();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_tag[i].valid;
        return v;
    endfunction

    // Level lev splits the entries into ranges of 16>>lev; each range owns one pointer bit
    function automatic int m_victim();
        int lo = 0;
        for (int i = 0; i < 16; i++) if (!m_tag[i].valid) return i;
        for (int lev = 0; lev < 4; lev++) if (m_pl[lev][lo / (16 >> lev)]) lo += 8 >> lev;
        return lo;
    endfunction

    function automatic void m_touch(int i);
        for (int lev = 0; lev < 4; lev++) m_pl[lev][i / (16 >> lev)] = (i % (16 >> lev)) < (8 >> lev);
    endfunction

    function automatic bit m_hit(tag_t t, bit ae, bit ve, logic [15:0] a, logic [26:0] vpn);
        logic [26:0] mask;
        mask = t.is_1G ? {9'h1ff, 18'h0} : t.is_2M ? {18'h3ffff, 9'h0} : {27{1'b1}};
        return (!ae || t.asid == a) && (!ve || ((({t.vpn2, t.vpn1, t.vpn0}) ^ vpn) & mask) == 27'h0);
    endfunction

    function automatic tag_t fill_tag();
        tag_t t;
        t.asid = bus.fill_asid_i;
        {t.vpn2, t.vpn1, t.vpn0} = bus.fill_vpn_i;
        t.is_1G = bus.fill_is_1G_i;
        t.is_2M = bus.fill_is_1G_i ? 1'b0 : bus.fill_is_2M_i;
        t.valid = 1'b1;
        return t;
    endfunction

    function automatic void m_reset();
        foreach (m_tag[i]) m_tag[i] = '0;
        foreach (m_pl[l, k]) m_pl[l][k] = 1'b0;
        q.delete();
        walk_end = 0;
    endfunction

    // One cycle: inputs already set at posedge+1; model applies what the next edge accepts
    task automatic tick();
        int v;
        exp_t e;
        bit idle;
        if (rnd_hits) bus.lookup_hit_i = $urandom_range(0, 2) == 0 ? 16'(1) << $urandom_range(0, 15) : 16'h0;
        #1;
        idle = cyc >= walk_end;
        fill_acc = bus.fill_valid_i && idle && !bus.flush_valid_i;
        flush_acc = bus.flush_valid_i && idle;
        if (bus.fill_valid_i) chk("fill_ready", bus.fill_ready_o, idle && !bus.flush_valid_i);
        if (bus.flush_valid_i) chk("flush_ready", bus.flush_ready_o, idle);
        v = m_victim();
        for (int i = 0; i < 16; i++) if (bus.lookup_hit_i[i]) m_touch(i);
        if (fill_acc) begin
            m_tag[v] = fill_tag();
            m_touch(v);
            e.is_flush = 1'b0; e.idx = v; e.tag = m_tag[v]; e.vic = m_victim(); e.valids = '0; e.t_acc = cyc;
            q.push_back(e);
            acc_cyc = cyc;
        end
        if (flush_acc) begin
            for (int i = 0; i < 16; i++)
                if (m_tag[i].valid && m_hit(m_tag[i], bus.flush_asid_en_i, bus.flush_vaddr_en_i,
                                            bus.flush_asid_i, bus.flush_vaddr_i[38:12])) m_tag[i].valid = 1'b0;
            e.is_flush = 1'b1; e.idx = 0; e.tag = '0; e.vic = 0; e.valids = m_valids(); e.t_acc = cyc;
            q.push_back(e);
            walk_end = cyc + 18;
            t_flush = cyc;
        end
        @(posedge clk);
        #1;
        bus.lookup_hit_i = '0;
    endtask

    task automatic fill(logic [15:0] asid, logic [26:0] vpn, bit m2, bit g1);
        bus.fill_valid_i = 1'b1;
        bus.fill_asid_i = asid;
        bus.fill_vpn_i = vpn;
        bus.fill_is_2M_i = m2;
        bus.fill_is_1G_i = g1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (fill_acc) break;
        end
        bus.fill_valid_i = 1'b0;
    endtask

    task automatic flush(bit ae, bit ve, logic [15:0] a, logic [38:0] va, bit check_busy);
        bus.flush_valid_i = 1'b1;
        bus.flush_asid_en_i = ae;
        bus.flush_vaddr_en_i = ve;
        bus.flush_asid_i = a;
        bus.flush_vaddr_i = va;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (flush_acc) break;
        end
        bus.flush_valid_i = 1'b0;
        if (check_busy) begin
            for (int k = 1; k <= 17; k++) begin
                chk("busy_walk", bus.busy_o, 1'b1);
                tick();
            end
            chk("busy_after", bus.busy_o, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        bit pend;
        exp_t e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) pend = 1'b0;
            else begin
                if (pend) begin
                    if (q.size() == 0 || q[0].is_flush) begin
                        n_cmp++; n_bad++;
                        $display("FAIL fill_sb: got an accepted fill, expected none (cycle %0d)", cyc);
                    end else begin
                        e = q.pop_front();
                        chk("fill_tag", bus.tags_o[e.idx], e.tag);
                        chk("fill_victim", bus.victim_o, e.vic);
                    end
                end
                if (bus.flush_done_o) begin
                    if (q.size() == 0 || !q[0].is_flush) begin
                        n_cmp++; n_bad++;
                        $display("FAIL flush_sb: got flush_done, expected none (cycle %0d)", cyc);
                    end else begin
                        e = q.pop_front();
                        chk("flush_valids", dut_valids(), e.valids);
                        chk("flush_latency", cyc - e.t_acc, 17);
                    end
                end
                pend = bus.fill_valid_i && bus.fill_ready_o;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [26:0] vpn;
        int op, idx;
        bus.fill_valid_i = 0; bus.fill_asid_i = '0; bus.fill_vpn_i = '0; bus.fill_is_2M_i = 0; bus.fill_is_1G_i = 0;
        bus.flush_valid_i = 0; bus.flush_asid_en_i = 0; bus.flush_vaddr_en_i = 0; bus.flush_asid_i = '0;
        bus.flush_vaddr_i = '0; bus.lookup_hit_i = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tags_zero", |bus.tags_o, 1'b0);
        chk("rst_victim", bus.victim_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.flush_done_o, 0);
        chk("rst_fill_ready", bus.fill_ready_o, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) fill(16'(i + 1), 27'($urandom), 0, 0);
        chk("victim_after3", bus.victim_o, 3);
        chk("busy_idle", bus.busy_o, 0);
        for (int i = 3; i < 16; i++) fill(16'(i + 1), 27'($urandom), 0, 0);
        chk("victim_full", bus.victim_o, 0);
        bus.lookup_hit_i = 16'h0001;
        tick();
        chk("victim_after_hit0", bus.victim_o, 8);
        fill(16'habcd, 27'h123, 0, 0);
        chk("fill17_entry8", bus.tags_o[8].asid, 16'habcd);
        do_reset();
        for (int i = 0; i < 8; i++) fill(i < 4 ? 16'd5 : 16'd7, 27'($urandom), 0, 0);
        flush(1, 0, 16'd5, '0, 1);
        chk("asid_flush_valids", dut_valids(), 16'h00f0);
        do_reset();
        fill(16'd1, {9'd1, 9'd2, 9'd9}, 1, 0);
        fill(16'd1, {9'd1, 9'd2, 9'd9}, 0, 0);
        flush(0, 1, '0, {9'd1, 9'd2, 9'd77, 12'h0}, 1);
        chk("va_flush_valids", dut_valids(), 16'h0002);
        bus.fill_valid_i = 1'b1; bus.fill_asid_i = 16'h77; bus.fill_vpn_i = 27'h55; bus.fill_is_2M_i = 0; bus.fill_is_1G_i = 0;
        bus.flush_valid_i = 1'b1; bus.flush_asid_en_i = 0; bus.flush_vaddr_en_i = 0;
        tick();
        bus.flush_valid_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (fill_acc) break;
        end
        bus.fill_valid_i = 1'b0;
        chk("fill_after_done", acc_cyc - t_flush, 18);
        for (int i = 0; i < 5; i++) fill(16'd3, 27'($urandom), 0, 0);
        flush(0, 0, '0, '0, 0);
        for (int k = 0; k < 40 && cyc < t_flush + 7; k++) tick();
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("midwalk_valids", dut_valids(), 16'h0);
        chk("midwalk_victim", bus.victim_o, 0);
        chk("midwalk_busy", bus.busy_o, 0);
        chk("midwalk_done", bus.flush_done_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) fill(16'd9, 27'($urandom), 0, 0);
        flush(0, 0, '0, '0, 1);
        chk("post_rst_flush_valids", dut_valids(), 16'h0);
        rnd_hits = 1'b1;
        for (int it = 0; it < 200; it++) begin
            op = $urandom_range(0, 9);
            if (op < 6)
                fill(16'($urandom_range(1, 3)), {9'($urandom_range(0, 3)), 9'($urandom_range(0, 3)), 9'($urandom_range(0, 3))},
                     1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            else if (op < 8) begin
                idx = $urandom_range(0, 15);
                vpn = {m_tag[idx].vpn2, m_tag[idx].vpn1, m_tag[idx].vpn0} ^ ($urandom_range(0, 1) ? 27'($urandom_range(0, 3)) : 27'h0);
                flush(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(1, 3)), {vpn, 12'($urandom)}, 0);
            end else tick();
        end
        rnd_hits = 1'b0;
        repeat (25) tick();
        chk("sb_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
